// File: rtl/dma_responder_pkg.sv
// rtl/dma_responder_pkg.sv - shared types and constants for the DMA memory responder
// Holds the responder FSM state type, the read-data value returned on failed
// accesses, and the width of the memory-ack timeout counter.
package dma_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_RESP
  } e_state;

  localparam logic [15:0] RDATA_ERROR = 16'hFFFF;
  localparam int          TMO_W       = 8;

endpackage

// File: rtl/dma_mem_port.sv
// rtl/dma_mem_port.sv - memory sub-port: request/ack handshake, field registers, timeout
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_start               launch one memory access (fields sampled this edge)
//   i_write/i_addr/i_wdata access fields, held on the mem_* outputs until done
//   o_mem_*/i_mem_*       memory channel handshake
//   o_done                mem_ack seen while a request is outstanding
//   o_timeout             counter reached TIMEOUT with no mem_ack this cycle
//   o_rdata               memory read data, valid with o_done
//   o_busy                an access (possibly a posted write) is still outstanding
module dma_mem_port
  import dma_responder_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic              o_mem_request,
  input  logic              i_mem_ack,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata,
  output logic              o_done,
  output logic              o_timeout,
  output logic [15:0]       o_rdata,
  output logic              o_busy
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  logic              r_mem_request;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [15:0]       r_mem_wdata;
  logic [TMO_W-1:0]  r_cnt;

  assign o_mem_request = r_mem_request;
  assign o_mem_write   = r_mem_write;
  assign o_mem_address = r_mem_address;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_busy        = r_mem_request;
  assign o_rdata       = i_mem_rdata;

  // A mem_ack in the final cycle beats the timeout.
  assign o_done    = r_mem_request && i_mem_ack;
  assign o_timeout = r_mem_request && !i_mem_ack && (r_cnt == TMO_LIMIT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mem_request <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_cnt         <= '0;
    end else if (i_start) begin
      r_mem_request <= 1'b1;
      r_mem_write   <= i_write;
      r_mem_address <= i_addr;
      r_mem_wdata   <= i_wdata;
      r_cnt         <= '0;
    end else if (r_mem_request) begin
      if (o_done || o_timeout) begin
        r_mem_request <= 1'b0;
        r_cnt         <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_memory_responder.sv
// rtl/dma_memory_responder.sv - DMA request/ack responder in front of a single-port memory channel
// Optional feature: DMA_WRITE_POST_EN (in-range writes are acked at once and
// completed by the memory sub-port in the background).
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   request/ack/write/address/wdata/rdata  CPU DMA side, one halfword per transfer
//   mem_request/mem_ack/mem_write/mem_address/mem_wdata/mem_rdata  memory side
//   error/error_clear               sticky range/timeout error and its clear
module dma_memory_responder
  import dma_responder_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              request,
  output logic              ack,
  input  logic              write,
  input  logic [31:0]       address,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              mem_request,
  input  logic              mem_ack,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              error,
  input  logic              error_clear
);

  e_state      r_state;
  logic        r_ack;
  logic        r_write;
  logic        r_error;
  logic [15:0] r_rdata;

  logic        w_out_of_range;
  logic        w_accept;
  logic        w_start;
  logic        w_post;
  logic        w_done;
  logic        w_timeout;
  logic        w_busy;
  logic        w_err_set;
  logic [15:0] w_mem_rdata;
  logic        w_unused_addr_bit0;

  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign error = r_error;

  // Byte address bit 0 has no meaning for halfword transfers.
  assign w_unused_addr_bit0 = address[0];

  assign w_out_of_range = (address >> (ADDR_W + 1)) != 32'd0;

  // A posted write still occupying the memory port holds off the next request.
  assign w_accept = (r_state == S_IDLE) && request && !w_busy;
  assign w_start  = w_accept && !w_out_of_range;

`ifdef DMA_WRITE_POST_EN
  assign w_post = write;
`else
  assign w_post = 1'b0;
`endif

  // Timeouts of posted writes are reported here too, whatever the FSM state.
  assign w_err_set = (w_accept && w_out_of_range) || w_timeout;

  dma_mem_port #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) u_mem_port (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_start      (w_start),
    .i_write      (write),
    .i_addr       (address[ADDR_W:1]),
    .i_wdata      (wdata),
    .o_mem_request(mem_request),
    .i_mem_ack    (mem_ack),
    .o_mem_write  (mem_write),
    .o_mem_address(mem_address),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_done       (w_done),
    .o_timeout    (w_timeout),
    .o_rdata      (w_mem_rdata),
    .o_busy       (w_busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_write <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= write;
            if (w_out_of_range) begin
              if (!write) r_rdata <= RDATA_ERROR;
              r_ack   <= 1'b1;
              r_state <= S_RESP;
            end else if (w_post) begin
              r_ack   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_MEM;
            end
          end
        end
        S_MEM: begin
          if (w_done) begin
            if (!r_write) r_rdata <= w_mem_rdata;
            r_ack   <= 1'b1;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            if (!r_write) r_rdata <= RDATA_ERROR;
            r_ack   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_error <= 1'b0;
    end else if (w_err_set) begin
      r_error <= 1'b1;
    end else if (error_clear) begin
      r_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_memory_responder.sv
// tb/tb_dma_memory_responder.sv - self-checking bench for dma_memory_responder
module tb_dma_memory_responder;

  localparam int ADDR_W  = 24;
  localparam int TIMEOUT = 255;
`ifdef DMA_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic              request;
  logic              ack;
  logic              write;
  logic [31:0]       address;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              mem_request;
  logic              mem_ack;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              error;
  logic              error_clear;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mem_arr [int];
  logic [15:0] m_rdata;
  logic        m_err;

  dma_memory_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .request    (request),
    .ack        (ack),
    .write      (write),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .mem_request(mem_request),
    .mem_ack    (mem_ack),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .error      (error),
    .error_clear(error_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int idx);
    return mem_arr.exists(idx) ? mem_arr[idx] : 16'h0000;
  endfunction

  // One transfer. Called #1 after an edge; the next edge is edge 0.
  // lat = cycles after mem_request rises before the memory gives mem_ack.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [15:0] d, input int lat);
    bit          oor;
    bit          posted;
    bit          tmo;
    bit          done;
    int          idx;
    int          ack_exp;
    int          rise;
    int          ack_cyc;
    int          ack_cnt;
    int          req_cnt;
    logic [15:0] rd_exp;

    oor    = (64'(a) >= (64'd1 << (ADDR_W + 1)));
    posted = POSTED && w && !oor;
    tmo    = !oor && (lat > TIMEOUT);
    idx    = int'((a / 32'd2) % (32'd1 << ADDR_W));
    if (oor || posted) ack_exp = 1;
    else if (tmo)      ack_exp = TIMEOUT + 2;
    else               ack_exp = lat + 2;
    rd_exp = m_rdata;
    if (!w) rd_exp = (oor || tmo) ? 16'hFFFF : mem_rd(idx);

    request = 1'b1;
    write   = w;
    address = a;
    wdata   = d;
    rise    = -1;
    ack_cyc = -1;
    ack_cnt = 0;
    req_cnt = 0;
    done    = 1'b0;

    for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = cyc;
          chk("rdata_at_ack", 32'(rdata), 32'(rd_exp));
        end
      end else begin
        chk("rdata_hold", 32'(rdata), 32'(ack_cyc < 0 ? m_rdata : rd_exp));
      end
      if (ack_cyc > 0 && cyc == ack_cyc + 1) request = 1'b0;
      if (mem_request) begin
        if (rise < 0) begin
          rise = cyc;
          chk("mem_address", 32'(mem_address), 32'(idx));
          chk("mem_write", 32'(mem_write), 32'(w));
          if (w) chk("mem_wdata", 32'(mem_wdata), 32'(d));
        end
        req_cnt++;
        mem_ack = ((cyc - rise) == lat);
        if (mem_ack && w) mem_arr[idx] = d;
        mem_rdata = mem_ack ? mem_rd(idx) : 16'($urandom);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
      end
      done = (ack_cyc > 0) && (cyc > ack_cyc) && !mem_request;
    end
    request = 1'b0;
    mem_ack = 1'b0;

    m_err   = m_err | oor | tmo;
    m_rdata = rd_exp;
    chk("xfer_completed", 32'(done), 32'd1);
    chk("ack_cycle", ack_cyc, ack_exp);
    chk("ack_pulses", ack_cnt, 1);
    chk("mem_req_rise", rise, oor ? -1 : 1);
    chk("mem_req_cycles", req_cnt, oor ? 0 : (tmo ? TIMEOUT + 1 : lat + 1));
    chk("error", 32'(error), 32'(m_err));
  endtask

  initial begin
    reset_n     = 1'b0;
    request     = 1'b0;
    write       = 1'b0;
    address     = '0;
    wdata       = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    error_clear = 1'b0;
    m_rdata     = '0;
    m_err       = 1'b0;

    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_request", 32'(mem_request), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    mem_arr[32'h91A] = 16'hA5C3;
    mem_arr[32'h080] = 16'h5AA5;
    mem_arr[32'h200] = 16'h0F1E;
    mem_arr[32'h201] = 16'hC0DE;

    xfer(1'b0, 32'h0000_1234, 16'h0000, 3);
    xfer(1'b1, 32'h0000_0002, 16'h1357, 0);
    xfer(1'b0, 32'h0000_0002, 16'h0000, 2);
    xfer(1'b0, 32'h0200_0000, 16'h0000, 0);

    error_clear = 1'b1;
    @(posedge clk);
    #1;
    error_clear = 1'b0;
    m_err = 1'b0;
    chk("error_clear", 32'(error), 32'd0);

    // Set and clear on the same edge: set must win.
    error_clear = 1'b1;
    request     = 1'b1;
    write       = 1'b0;
    address     = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    error_clear = 1'b0;
    chk("setwins_ack", 32'(ack), 32'd1);
    chk("setwins_error", 32'(error), 32'd1);
    chk("setwins_rdata", 32'(rdata), 32'hFFFF);
    @(posedge clk);
    #1;
    request = 1'b0;
    chk("setwins_ack_drop", 32'(ack), 32'd0);
    chk("setwins_error_held", 32'(error), 32'd1);
    m_err   = 1'b1;
    m_rdata = 16'hFFFF;
    error_clear = 1'b1;
    @(posedge clk);
    #1;
    error_clear = 1'b0;
    m_err = 1'b0;

    xfer(1'b0, 32'h0000_0100, 16'h0000, TIMEOUT);
    xfer(1'b0, 32'h0000_0200, 16'h0000, 1000);
    chk("tmo_mem_req_low", 32'(mem_request), 32'd0);

    // Reset asserted while waiting in MEM.
    request = 1'b1;
    write   = 1'b0;
    address = 32'h0000_0300;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_mem_request", 32'(mem_request), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_request", 32'(mem_request), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    request = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_err   = 1'b0;
    m_rdata = '0;
    xfer(1'b0, 32'h0000_1234, 16'h0000, 1);

    // Back-to-back reads: request stays high across the ack edge.
    xfer(1'b0, 32'h0000_0400, 16'h0000, 1);
    xfer(1'b0, 32'h0000_0402, 16'h0000, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 5) == 0) a = 32'h0200_0000 | 32'($urandom);
      else                           a = 32'($urandom) & 32'h01FF_FFFF;
      xfer(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
